// File: rtl/br_lite_ni_pkg.sv
// Shared types for the BrLiteNoC network interface.
package br_lite_ni_pkg;

  localparam int unsigned BR_ADDR_W    = 8;
  localparam int unsigned BR_PAYLOAD_W = 16;
  localparam int unsigned BR_ID_W      = 5;

  // Service carried by a flit: broadcast to all PEs or addressed to one target.
  typedef enum logic [1:0] {
    BR_SVC_TGT = 2'd0,
    BR_SVC_ALL = 2'd1,
    BR_SVC_CLR = 2'd2,
    BR_SVC_RSV = 2'd3
  } br_svc_t;

  // Flit exchanged with the router local port.
  typedef struct packed {
    logic [BR_ADDR_W-1:0]    seq_source;
    logic [BR_ADDR_W-1:0]    seq_target;
    logic [BR_PAYLOAD_W-1:0] payload;
    br_svc_t                 service;
    logic [BR_ID_W-1:0]      id;
  } br_data_t;

  // TX queue entry; source and id are stamped only when the entry departs.
  typedef struct packed {
    logic [BR_ADDR_W-1:0]    target;
    logic [BR_PAYLOAD_W-1:0] payload;
    br_svc_t                 service;
  } br_tx_entry_t;

endpackage

// File: rtl/br_lite_ni.sv
// br_lite_ni: per-PE network interface to the BrLiteNoC router local port.
// TX queues PE requests and injects them with a four-phase req/ack handshake
// gated by the router busy flag; RX accepts router deliveries into a FIFO
// read by the PE through valid/ready.
module br_lite_ni
  import br_lite_ni_pkg::*;
#(
  parameter logic [BR_ADDR_W-1:0] SRC_ADDR = '0,
  parameter int unsigned          TX_DEPTH = 4,
  parameter int unsigned          RX_DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       tx_valid_i,
  output logic                       tx_ready_o,
  input  logic [BR_ADDR_W-1:0]       tx_target_i,
  input  logic [BR_PAYLOAD_W-1:0]    tx_payload_i,
  input  br_svc_t                    tx_service_i,
  output br_data_t                   noc_flit_o,
  output logic                       noc_req_o,
  input  logic                       noc_ack_i,
  input  logic                       noc_busy_i,
  input  br_data_t                   noc_flit_i,
  input  logic                       noc_req_i,
  output logic                       noc_ack_o,
  output logic                       rx_valid_o,
  input  logic                       rx_ready_i,
  output br_data_t                   rx_flit_o,
  output logic [$clog2(TX_DEPTH):0]  tx_level_o,
  output logic [$clog2(RX_DEPTH):0]  rx_level_o
);

  localparam int unsigned TX_PW = $clog2(TX_DEPTH);
  localparam int unsigned TX_LW = TX_PW + 1;
  localparam int unsigned RX_PW = $clog2(RX_DEPTH);
  localparam int unsigned RX_LW = RX_PW + 1;

  typedef enum logic [1:0] {
    TX_IDLE = 2'd0,
    TX_REQ  = 2'd1,
    TX_REL  = 2'd2
  } tx_state_e;

  typedef enum logic {
    RX_IDLE = 1'b0,
    RX_ACK  = 1'b1
  } rx_state_e;

  // ---------------------------------------------------------------- TX side
  br_tx_entry_t     r_tx_mem [TX_DEPTH];
  logic [TX_PW-1:0] r_tx_wr;
  logic [TX_PW-1:0] r_tx_rd;
  logic [TX_LW-1:0] r_tx_level;
  tx_state_e        r_tx_state;
  tx_state_e        w_tx_next;
  br_data_t         r_noc_flit;
  logic [BR_ID_W-1:0] r_id_cnt;
  br_tx_entry_t     w_tx_entry;
  br_tx_entry_t     w_tx_head;
  logic             w_tx_push;
  logic             w_tx_pop;
  logic             w_tx_empty;
  logic             w_tx_full;

  assign w_tx_entry = '{target: tx_target_i, payload: tx_payload_i, service: tx_service_i};
  assign w_tx_head  = r_tx_mem[r_tx_rd];
  assign w_tx_empty = (r_tx_level == '0);
  assign w_tx_full  = (r_tx_level == TX_LW'(TX_DEPTH));
  assign w_tx_push  = tx_valid_i & ~w_tx_full;

  assign tx_ready_o = ~w_tx_full;
  assign tx_level_o = r_tx_level;
  assign noc_flit_o = r_noc_flit;

  // TX FIFO storage and write pointer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < TX_DEPTH; i++) r_tx_mem[i] <= '0;
      r_tx_wr <= '0;
    end else if (w_tx_push) begin
      r_tx_mem[r_tx_wr] <= w_tx_entry;
      r_tx_wr           <= r_tx_wr + TX_PW'(1);
    end
  end

  // TX FIFO read pointer and occupancy
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tx_rd    <= '0;
      r_tx_level <= '0;
    end else begin
      if (w_tx_pop) r_tx_rd <= r_tx_rd + TX_PW'(1);
      case ({w_tx_push, w_tx_pop})
        2'b10:   r_tx_level <= r_tx_level + TX_LW'(1);
        2'b01:   r_tx_level <= r_tx_level - TX_LW'(1);
        default: r_tx_level <= r_tx_level;
      endcase
    end
  end

  // TX state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_tx_state <= TX_IDLE;
    else        r_tx_state <= w_tx_next;
  end

  // TX next state: launch a queued request only while the router is not busy
  always_comb begin
    w_tx_next = r_tx_state;
    w_tx_pop  = 1'b0;
    case (r_tx_state)
      TX_IDLE: begin
        if (!w_tx_empty && !noc_busy_i) begin
          w_tx_next = TX_REQ;
          w_tx_pop  = 1'b1;
        end
      end
      TX_REQ:  if (noc_ack_i)  w_tx_next = TX_REL;
      TX_REL:  if (!noc_ack_i) w_tx_next = TX_IDLE;
      default: w_tx_next = TX_IDLE;
    endcase
  end

  // TX handshake output: request held for the whole TX_REQ phase
  always_comb begin
    noc_req_o = 1'b0;
    if (r_tx_state == TX_REQ) noc_req_o = 1'b1;
  end

  // Launch register: stamp source address and packet id on the departing flit
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_noc_flit <= '0;
      r_id_cnt   <= '0;
    end else if (w_tx_pop) begin
      r_noc_flit.seq_source <= SRC_ADDR;
      r_noc_flit.seq_target <= w_tx_head.target;
      r_noc_flit.payload    <= w_tx_head.payload;
      r_noc_flit.service    <= w_tx_head.service;
      r_noc_flit.id         <= r_id_cnt;
      r_id_cnt              <= r_id_cnt + BR_ID_W'(1);
    end
  end

  // ---------------------------------------------------------------- RX side
  br_data_t         r_rx_mem [RX_DEPTH];
  logic [RX_PW-1:0] r_rx_wr;
  logic [RX_PW-1:0] r_rx_rd;
  logic [RX_LW-1:0] r_rx_level;
  rx_state_e        r_rx_state;
  rx_state_e        w_rx_next;
  logic             w_rx_push;
  logic             w_rx_pop;
  logic             w_rx_full;
  logic             w_rx_empty;

  assign w_rx_full  = (r_rx_level == RX_LW'(RX_DEPTH));
  assign w_rx_empty = (r_rx_level == '0);
  assign w_rx_pop   = ~w_rx_empty & rx_ready_i;

  assign rx_valid_o = ~w_rx_empty;
  assign rx_flit_o  = r_rx_mem[r_rx_rd];
  assign rx_level_o = r_rx_level;

  // RX FIFO storage and write pointer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < RX_DEPTH; i++) r_rx_mem[i] <= '0;
      r_rx_wr <= '0;
    end else if (w_rx_push) begin
      r_rx_mem[r_rx_wr] <= noc_flit_i;
      r_rx_wr           <= r_rx_wr + RX_PW'(1);
    end
  end

  // RX FIFO read pointer and occupancy
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rx_rd    <= '0;
      r_rx_level <= '0;
    end else begin
      if (w_rx_pop) r_rx_rd <= r_rx_rd + RX_PW'(1);
      case ({w_rx_push, w_rx_pop})
        2'b10:   r_rx_level <= r_rx_level + RX_LW'(1);
        2'b01:   r_rx_level <= r_rx_level - RX_LW'(1);
        default: r_rx_level <= r_rx_level;
      endcase
    end
  end

  // RX state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_rx_state <= RX_IDLE;
    else        r_rx_state <= w_rx_next;
  end

  // RX next state: accept only against the registered level, so a full FIFO
  // back-pressures the router even if the PE pops in the same cycle
  always_comb begin
    w_rx_next = r_rx_state;
    w_rx_push = 1'b0;
    case (r_rx_state)
      RX_IDLE: begin
        if (noc_req_i && !w_rx_full) begin
          w_rx_next = RX_ACK;
          w_rx_push = 1'b1;
        end
      end
      RX_ACK:  if (!noc_req_i) w_rx_next = RX_IDLE;
      default: w_rx_next = RX_IDLE;
    endcase
  end

  // RX handshake output: acknowledge held until the router drops its request
  always_comb begin
    noc_ack_o = 1'b0;
    if (r_rx_state == RX_ACK) noc_ack_o = 1'b1;
  end

endmodule
